// File: rtl/seat_access_arbiter.sv
// rtl/seat_access_arbiter.sv - round-robin arbiter for seat reserve/release requests into the seating system
// Optional auto-release of stale reservations is compiled in with SEAT_TIMEOUT_EN.
module seat_access_arbiter #(
    parameter int          NUM_REQ    = 3,
    parameter logic [10:0] HOLD_LIMIT = 11'd60
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*25-1:0]  req_student,
    input  logic [NUM_REQ*5-1:0]   req_seat,
    input  logic [NUM_REQ-1:0]     req_op,
    input  logic [10:0]            Time,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   done,
    output logic [1:0]             result,
    output logic [24:0]            Student_No,
    output logic [4:0]             Seat_No,
    output logic                   write,
    output logic [1:0]             Seat_State
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef SEAT_TIMEOUT_EN
    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_WRITE, S_RESP, S_SCAN} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_WRITE, S_RESP} state_t;
`endif

    state_t        state_q, state_d;
    logic [IW-1:0] rr_q, rr_d;
    logic [IW-1:0] win_q, win_d;
    logic [24:0]   stu_q, stu_d;
    logic [4:0]    seat_q, seat_d;
    logic          op_q, op_d;
    logic [1:0]    result_q, result_d;
    logic [24:0]   student_no_q, student_no_d;
    logic [4:0]    seat_no_q, seat_no_d;
    logic [1:0]    seat_state_q, seat_state_d;
    logic [4:0]    scan_q, scan_d;

    logic [31:0]   valid_q, valid_d;
    logic [24:0]   owner_q [32];
    logic [24:0]   owner_d [32];
    logic [10:0]   stamp_q [32];
    logic [10:0]   stamp_d [32];

    logic          found;
    logic [IW-1:0] pick;
    logic [IW-1:0] rr_next;
    int            pick_j;
    logic [1:0]    check_res;
    logic [4:0]    scan_next;

    // Search starts at the pointer and wraps, so the first hit is the round-robin winner.
    always_comb begin
        found  = 1'b0;
        pick   = '0;
        pick_j = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pick_j = int'(rr_q) + k;
            if (pick_j >= NUM_REQ) begin
                pick_j = pick_j - NUM_REQ;
            end
            if (!found && req[IW'(pick_j)]) begin
                found = 1'b1;
                pick  = IW'(pick_j);
            end
        end
        rr_next = (pick == IW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
    end

    always_comb begin
        check_res = 2'b00;
        if (seat_q == 5'd0) begin
            check_res = 2'b11;
        end else if (!op_q) begin
            if (valid_q[seat_q] && owner_q[seat_q] != stu_q) begin
                check_res = 2'b01;
            end
        end else begin
            if (!valid_q[seat_q] || owner_q[seat_q] != stu_q) begin
                check_res = 2'b10;
            end
        end
    end

    assign scan_next = (scan_q == 5'd31) ? 5'd1 : scan_q + 5'd1;

`ifdef SEAT_TIMEOUT_EN
    logic [10:0] age;
    assign age = Time - stamp_q[scan_q];
`else
    logic unused_default;
    always_comb begin
        unused_default = ^scan_q ^ ^scan_next;
        for (int i = 0; i < 32; i++) begin
            unused_default = unused_default ^ (^stamp_q[i]);
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        win_d        = win_q;
        stu_d        = stu_q;
        seat_d       = seat_q;
        op_d         = op_q;
        result_d     = result_q;
        student_no_d = student_no_q;
        seat_no_d    = seat_no_q;
        seat_state_d = seat_state_q;
        scan_d       = scan_q;
        valid_d      = valid_q;
        owner_d      = owner_q;
        stamp_d      = stamp_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    win_d   = pick;
                    rr_d    = rr_next;
                    stu_d   = req_student[25*pick +: 25];
                    seat_d  = req_seat[5*pick +: 5];
                    op_d    = req_op[pick];
                    state_d = S_CHECK;
                end
`ifdef SEAT_TIMEOUT_EN
                else if (valid_q[scan_q] && age >= HOLD_LIMIT) begin
                    seat_d       = scan_q;
                    student_no_d = owner_q[scan_q];
                    seat_no_d    = scan_q;
                    seat_state_d = 2'b01;
                    scan_d       = scan_next;
                    state_d      = S_SCAN;
                end else begin
                    scan_d = scan_next;
                end
`endif
            end
            S_CHECK: begin
                result_d = check_res;
                if (check_res == 2'b00) begin
                    student_no_d = stu_q;
                    seat_no_d    = seat_q;
                    seat_state_d = op_q ? 2'b01 : 2'b11;
                    state_d      = S_WRITE;
                end else begin
                    state_d = S_RESP;
                end
            end
            S_WRITE: begin
                if (op_q) begin
                    valid_d[seat_q] = 1'b0;
                end else begin
                    valid_d[seat_q] = 1'b1;
                    owner_d[seat_q] = stu_q;
                    stamp_d[seat_q] = Time;
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
`ifdef SEAT_TIMEOUT_EN
            S_SCAN: begin
                valid_d[seat_q] = 1'b0;
                state_d         = S_IDLE;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rr_q         <= '0;
            win_q        <= '0;
            stu_q        <= '0;
            seat_q       <= '0;
            op_q         <= 1'b0;
            result_q     <= 2'b00;
            student_no_q <= '0;
            seat_no_q    <= '0;
            seat_state_q <= 2'b00;
            scan_q       <= 5'd1;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            win_q        <= win_d;
            stu_q        <= stu_d;
            seat_q       <= seat_d;
            op_q         <= op_d;
            result_q     <= result_d;
            student_no_q <= student_no_d;
            seat_no_q    <= seat_no_d;
            seat_state_q <= seat_state_d;
            scan_q       <= scan_d;
            valid_q      <= valid_d;
        end
    end

    // Owner and stamp are only meaningful while valid is set, so they need no reset.
    always_ff @(posedge clk) begin
        owner_q <= owner_d;
        stamp_q <= stamp_d;
    end

    assign grant      = (state_q == S_CHECK) ? (NUM_REQ'(1) << win_q) : '0;
`ifdef SEAT_TIMEOUT_EN
    assign write      = (state_q == S_WRITE) || (state_q == S_SCAN);
`else
    assign write      = (state_q == S_WRITE);
`endif
    assign done       = (state_q == S_RESP);
    assign result     = result_q;
    assign Student_No = student_no_q;
    assign Seat_No    = seat_no_q;
    assign Seat_State = seat_state_q;

endmodule

// File: tb/tb_seat_access_arbiter.sv
// tb/tb_seat_access_arbiter.sv - self-checking bench for seat_access_arbiter (default build)
module tb_seat_access_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [74:0] req_student;
    logic [14:0] req_seat;
    logic [2:0]  req_op;
    logic [10:0] Time;
    logic [2:0]  grant;
    logic        done;
    logic [1:0]  result;
    logic [24:0] Student_No;
    logic [4:0]  Seat_No;
    logic        write;
    logic [1:0]  Seat_State;

    seat_access_arbiter #(.NUM_REQ(3), .HOLD_LIMIT(11'd60)) dut (
        .clk(clk), .reset(reset), .req(req), .req_student(req_student),
        .req_seat(req_seat), .req_op(req_op), .Time(Time), .grant(grant),
        .done(done), .result(result), .Student_No(Student_No), .Seat_No(Seat_No),
        .write(write), .Seat_State(Seat_State)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    bit          m_valid [32];
    logic [24:0] m_owner [32];
    int          m_rr;
    logic [24:0] t_stu  [3];
    logic [4:0]  t_seat [3];
    logic        t_op   [3];

    typedef struct {
        int          t;
        logic [24:0] stu;
        logic [4:0]  seat;
        logic        op;
        int          exp_res;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
        m_rr = 0;
    endtask

    function automatic int model_result(input int t);
        logic [4:0] s;
        s = t_seat[t];
        if (s == 5'd0) return 3;
        if (!t_op[t]) return (!m_valid[s] || m_owner[s] == t_stu[t]) ? 0 : 1;
        return (m_valid[s] && m_owner[s] == t_stu[t]) ? 0 : 2;
    endfunction

    task automatic set_term(input int t, input logic [24:0] stu, input logic [4:0] seat, input logic op);
        t_stu[t]  = stu;
        t_seat[t] = seat;
        t_op[t]   = op;
        req_student[25*t +: 25] = stu;
        req_seat[5*t +: 5]      = seat;
        req_op[t]               = op;
        req[t]                  = 1'b1;
    endtask

    // Waits for the next grant, checks it against the round-robin rule and the response timing.
    task automatic serve(input int exp_table, output int g);
        bit got;
        int w;
        int er;
        got = 0;
        g   = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(posedge clk); #1;
            if (grant != 3'b000) got = 1;
        end
        if (!got) begin
            chk("grant_timeout", 32'd0, 32'd1);
            req = 3'b000;
            return;
        end
        g = int'(grant);
        w = -1;
        for (int k = 0; k < 3; k++) begin
            int j;
            j = (m_rr + k) % 3;
            if (w < 0 && req[j]) w = j;
        end
        if (w < 0) w = 0;
        chk("grant_rr", grant, 32'd1 << w);
        m_rr   = (w + 1) % 3;
        req[w] = 1'b0;
        er = (exp_table >= 0) ? exp_table : model_result(w);
        @(posedge clk); #1;
        if (er == 0) begin
            chk("write_pulse", write, 1);
            chk("done_during_write", done, 0);
            chk("write_seat_no", Seat_No, t_seat[w]);
            chk("write_student_no", Student_No, t_stu[w]);
            chk("write_seat_state", Seat_State, t_op[w] ? 2'b01 : 2'b11);
            @(posedge clk); #1;
            chk("done_ok", done, 1);
            chk("write_during_done", write, 0);
            chk("result_ok", result, 0);
            if (t_op[w]) m_valid[t_seat[w]] = 1'b0;
            else begin
                m_valid[t_seat[w]] = 1'b1;
                m_owner[t_seat[w]] = t_stu[w];
            end
        end else begin
            chk("no_write_on_error", write, 0);
            chk("done_err", done, 1);
            chk("result_err", result, er);
        end
        @(posedge clk); #1;
        chk("idle_quiet", {30'd0, done, write}, 32'd0);
    endtask

    initial begin
        int g;
        int wcount;
        bit got;
        reset = 1'b1; req = '0; req_student = '0; req_seat = '0; req_op = '0; Time = 11'd0;
        model_reset();
        vecs[0]  = '{0, 25'h1FFFFFF, 5'd1,  1'b0, 0};
        vecs[1]  = '{1, 25'h1EC10F3, 5'd1,  1'b0, 1};
        vecs[2]  = '{1, 25'h0000123, 5'd0,  1'b0, 3};
        vecs[3]  = '{2, 25'h0000456, 5'd5,  1'b1, 2};
        vecs[4]  = '{0, 25'h1FFFFFF, 5'd1,  1'b0, 0};
        vecs[5]  = '{2, 25'h1EC10F3, 5'd1,  1'b1, 2};
        vecs[6]  = '{0, 25'h1FFFFFF, 5'd1,  1'b1, 0};
        vecs[7]  = '{1, 25'h1EC10F3, 5'd1,  1'b0, 0};
        vecs[8]  = '{1, 25'h1EC10F3, 5'd1,  1'b1, 0};
        vecs[9]  = '{0, 25'h0000777, 5'd31, 1'b0, 0};
        vecs[10] = '{2, 25'h0000888, 5'd31, 1'b0, 1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_done", done, 0);
        chk("rst_write", write, 0);
        chk("rst_result", result, 0);
        chk("rst_student", Student_No, 0);
        chk("rst_seat", Seat_No, 0);
        chk("rst_state", Seat_State, 0);
        reset = 1'b0;

        // Simultaneous requests straight after reset: pointer starts at terminal 0.
        set_term(0, 25'h0000A0A, 5'd3, 1'b0);
        set_term(1, 25'h0000B0B, 5'd4, 1'b0);
        set_term(2, 25'h0000C0C, 5'd3, 1'b0);
        serve(-1, g); chk("rr_first", g, 3'b001);
        serve(-1, g); chk("rr_second", g, 3'b010);
        serve(-1, g); chk("rr_third", g, 3'b100);
        set_term(0, 25'h0000A0A, 5'd3, 1'b1);
        serve(-1, g); chk("rr_wrap", g, 3'b001);

        for (int i = 0; i < 11; i++) begin
            set_term(vecs[i].t, vecs[i].stu, vecs[i].seat, vecs[i].op);
            serve(vecs[i].exp_res, g);
        end

        // Stale reservation must persist when auto-release is not compiled in.
        Time = 11'd2040;
        set_term(0, 25'h0000ABC, 5'd2, 1'b0);
        serve(0, g);
        Time = 11'd52;
        wcount = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (write) wcount++;
        end
        chk("no_autorelease_write", wcount, 0);
        set_term(0, 25'h0000ABC, 5'd2, 1'b1);
        serve(0, g);

        // Reset during CHECK aborts the reserve with no write.
        set_term(1, 25'h0000055, 5'd9, 1'b0);
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(posedge clk); #1;
            if (grant != 3'b000) got = 1;
        end
        chk("abort_grant_seen", got, 1);
        reset = 1'b1;
        req   = 3'b000;
        @(posedge clk); #1;
        chk("abort_write", write, 0);
        chk("abort_done", done, 0);
        chk("abort_grant", grant, 0);
        chk("abort_result", result, 0);
        chk("abort_student", Student_No, 0);
        chk("abort_seat", Seat_No, 0);
        chk("abort_seat_state", Seat_State, 0);
        @(posedge clk); #1;
        chk("abort_write_late", write, 0);
        reset = 1'b0;
        model_reset();
        set_term(1, 25'h0000055, 5'd9, 1'b0);
        serve(0, g);

        for (int r = 0; r < 40; r++) begin
            int mask;
            mask = $urandom_range(1, 7);
            for (int t = 0; t < 3; t++) begin
                if (mask[t]) begin
                    set_term(t, 25'h1000 * $urandom_range(1, 3), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
                end
            end
            for (int s = 0; s < 3 && req != 3'b000; s++) begin
                serve(-1, g);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seat_access_arbiter.md
SEAT_ACCESS_ARBITER -- requirements
Module: seat_access_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3: number of requesting terminals.
REQ-002 Parameter HOLD_LIMIT, default 11'd60: Time units a reservation may stand before auto-release.
REQ-003 clk  in  1  rising-edge clock, the only clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req  in  NUM_REQ  per-terminal request level; held until that terminal's grant bit is seen.
REQ-006 req_student  in  NUM_REQ*25  packed student numbers; terminal i uses bits [25i+24:25i].
REQ-007 req_seat  in  NUM_REQ*5  packed seat numbers; terminal i uses bits [5i+4:5i].
REQ-008 req_op  in  NUM_REQ  per terminal: 0 = reserve, 1 = release.
REQ-009 Time  in  11  free-running time stamp; wraps modulo 2048.
REQ-010 grant  out  NUM_REQ  one-hot, one-cycle pulse naming the accepted terminal.
REQ-011 done  out  1  one-cycle pulse; result is valid in that cycle.
REQ-012 result  out  2  00 ok, 01 seat busy, 10 not owner, 11 invalid seat.
REQ-013 Student_No  out  25  student number driven to the seating system.
REQ-014 Seat_No  out  5  seat number driven to the seating system.
REQ-015 write  out  1  one-cycle write strobe to the seating system.
REQ-016 Seat_State  out  2  2'b11 occupied, 2'b01 free.

Function
REQ-017 The block SHALL keep an internal table of 32 entries, each holding valid, owner (25 bits) and stamp (11 bits).
REQ-018 The FSM SHALL have the states IDLE, CHECK, WRITE, RESP and SCAN.
REQ-019 In IDLE with any req bit high, the block SHALL pick a winner round-robin, starting from the index after the last winner (index 0 after reset).
REQ-020 On that pick the block SHALL capture the winner's student, seat and op, pulse grant for exactly the CHECK cycle, and enter CHECK.
REQ-021 CHECK SHALL decide the result as follows:
- seat 0 -> 11
- reserve, seat free -> ok
- reserve, seat held by the same student -> ok, stamp refreshed
- reserve, seat held by another student -> 01
- release, seat held by the requester -> ok
- release, seat free or held by another student -> 10
REQ-022 An ok result SHALL go to WRITE; any other result SHALL go directly to RESP.
REQ-023 In WRITE the block SHALL hold write=1 for one cycle with Student_No, Seat_No and Seat_State set:
- reserve -> 11
- release -> 01
REQ-024 In the WRITE cycle the table entry SHALL be updated: reserve sets valid and stores Time; release clears valid.
REQ-025 RESP SHALL pulse done with result for one cycle and then return to IDLE.
REQ-026 Request-to-done latency SHALL be 3 cycles for ok and 2 cycles otherwise, counted from the IDLE edge that samples req.
REQ-027 write and done SHALL never be high in the same cycle.
REQ-028 Outside WRITE, write SHALL be 0 and Student_No, Seat_No and Seat_State SHALL hold their last values.
REQ-029 req changes outside IDLE SHALL be ignored; a terminal whose req stays high after its grant is treated as a new request.
REQ-030 The round-robin pointer SHALL advance only on grant.

Reset
REQ-031 On reset the block SHALL set the following:
- state IDLE
- all table valid bits 0
- round-robin pointer 0
- scan index 1
- grant 0, done 0, result 00, write 0
- Student_No 0, Seat_No 0, Seat_State 00
REQ-032 A reset asserted mid-operation SHALL abort it with no write issued in the following cycle.

Configuration
REQ-033 Macro SEAT_TIMEOUT_EN SHALL compile auto-release in.
- Defined: in IDLE with req all 0, the block SHALL test one entry per cycle at the scan index (1..31, wrapping 31->1).
- If that entry is valid and (Time - stamp) mod 2048 >= HOLD_LIMIT, the block SHALL go to SCAN.
- SCAN SHALL issue one write with that seat, its owner and Seat_State 01, clear valid, raise no done, and return to IDLE.
- A request present in IDLE SHALL take priority over scanning.
- Undefined: no SCAN state, reservations persist until released, Time ignored.

Verification
REQ-034 T0 reserves seat 1 for 25'h1FFFFFF -> grant=001, write with Seat_State 11 on cycle +2, done with result 00 on cycle +3.
REQ-035 T1 reserves seat 1 for 25'h1EC10F3 while it is held -> no write, done with result 01 on cycle +2.
REQ-036 T0, T1 and T2 request together -> grants in order 001, 010, 100, then a new T0 request is granted next.
REQ-037 Seat 0 -> result 11; T2 releases seat 5 it does not own -> result 10.
REQ-038 With SEAT_TIMEOUT_EN, reserve seat 2 at Time 2040, advance Time to 52 -> write with Seat_No 2 and Seat_State 01, no done; without the macro -> no write.
REQ-039 Assert reset in the CHECK cycle -> write stays 0, all outputs at reset values, and the reserve that was aborted now returns result 00.
